// File: rtl/forward_pkg.sv
// Shared types and helpers for the forwarding scoreboard: slot layout and
// clamping of the producer's forwardable-from stage.
package forward_pkg;

   // Slot fields are sized for the widest supported configuration
   // (REGW <= 8, DEPTH <= 15); narrower configurations zero-extend into them.
   localparam int FWD_DEST_W  = 8;
   localparam int FWD_AVAIL_W = 4;
   localparam int FWD_RF      = 0;

   typedef struct packed {
      logic                   valid;
      logic                   wen;
      logic [FWD_DEST_W-1:0]  dest;
      logic [FWD_AVAIL_W-1:0] avail;
   } fwd_slot_t;

   // A result can never be forwardable before slot 1 or after the last slot.
   function automatic logic [FWD_AVAIL_W-1:0] clamp_avail(
      input logic [FWD_AVAIL_W-1:0] avail,
      input int                     depth
   );
      if (avail == '0)
         return FWD_AVAIL_W'(1);
      if (avail > FWD_AVAIL_W'(depth))
         return FWD_AVAIL_W'(depth);
      return avail;
   endfunction

endpackage

// File: rtl/fwd_src_select.sv
// Priority match of one source operand against every tracked slot; the
// youngest (lowest-index) matching producer decides forward vs. stall.
import forward_pkg::*;

module fwd_src_select #(
   parameter int DEPTH = 2,
   parameter int REGW  = 5,
   parameter int SELW  = 2
) (
   input  fwd_slot_t        slots [1:DEPTH],
   input  logic [REGW-1:0]  src_addr,
   input  logic             src_used,
   output logic [SELW-1:0]  sel,
   output logic             stall
);

   logic [DEPTH:1] match;
   logic [DEPTH:1] ready;

   generate
      for (genvar gi = 1; gi <= DEPTH; gi++) begin : g_slot
         assign match[gi] = src_used && slots[gi].valid && slots[gi].wen &&
                            (slots[gi].dest == FWD_DEST_W'(src_addr)) &&
                            (src_addr != '0);
         assign ready[gi] = (slots[gi].avail <= FWD_AVAIL_W'(gi));
      end
   endgenerate

   // Walk oldest to youngest so the youngest match overwrites older ones.
   always_comb begin
      sel   = SELW'(FWD_RF);
      stall = 1'b0;
      for (int k = DEPTH; k >= 1; k--) begin
         if (match[k]) begin
            if (ready[k]) begin
               sel   = SELW'(k);
               stall = 1'b0;
            end else begin
               sel   = SELW'(FWD_RF);
               stall = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/forward_scoreboard.sv
// Shift-register scoreboard of in-flight register writes past EX, producing
// per-operand forwarding selects, a load-use stall and a stall-cycle counter.
import forward_pkg::*;

module forward_scoreboard #(
   parameter  int DEPTH = 2,
   parameter  int NSRC  = 2,
   parameter  int REGW  = 5,
   parameter  int CNTW  = 32,
   localparam int SELW  = $clog2(DEPTH + 1)
) (
   input  logic                   CLK,
   input  logic                   nRST,
   input  logic                   ex_valid,
   input  logic                   ex_wen,
   input  logic [REGW-1:0]        ex_dest,
   input  logic [SELW-1:0]        ex_avail,
   input  logic [NSRC*REGW-1:0]   src_addr,
   input  logic [NSRC-1:0]        src_used,
   input  logic                   stall_in,
   input  logic                   flush,
   input  logic                   cnt_clr,
   output logic [NSRC*SELW-1:0]   fwd_sel,
   output logic                   hazard_stall,
   output logic [CNTW-1:0]        stall_cnt
);

   fwd_slot_t       slots_reg [1:DEPTH];
   fwd_slot_t       slot_in_next;
   logic [NSRC-1:0] src_stall;
   logic [CNTW-1:0] cnt_reg;

   generate
      for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
         fwd_src_select #(
            .DEPTH (DEPTH),
            .REGW  (REGW),
            .SELW  (SELW)
         ) u_select (
            .slots    (slots_reg),
            .src_addr (src_addr[gi*REGW +: REGW]),
            .src_used (src_used[gi]),
            .sel      (fwd_sel[gi*SELW +: SELW]),
            .stall    (src_stall[gi])
         );
      end
   endgenerate

   assign hazard_stall = ex_valid & (|src_stall);

   // A stalled or squashed EX instruction enters the pipe as a bubble.
   always_comb begin
      slot_in_next.valid = ex_valid & ex_wen & ~hazard_stall & ~flush;
      slot_in_next.wen   = ex_wen;
      slot_in_next.dest  = FWD_DEST_W'(ex_dest);
      slot_in_next.avail = clamp_avail(FWD_AVAIL_W'(ex_avail), DEPTH);
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int k = 1; k <= DEPTH; k++)
            slots_reg[k] <= '0;
      end else if (!stall_in) begin
         slots_reg[1] <= slot_in_next;
         for (int k = 2; k <= DEPTH; k++)
            slots_reg[k] <= slots_reg[k-1];
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)
         cnt_reg <= '0;
      else if (cnt_clr)
         cnt_reg <= '0;
      else if (hazard_stall && !stall_in && (cnt_reg != '1))
         cnt_reg <= cnt_reg + 1'b1;
   end

   assign stall_cnt = cnt_reg;

endmodule

// File: tb/tb_forward_scoreboard.sv
// Self-checking bench for forward_scoreboard: expected outputs are queued as
// each EX cycle is driven and popped when the DUT output is sampled.
module tb_forward_scoreboard;

   localparam int DEPTH = 2;
   localparam int NSRC  = 2;
   localparam int REGW  = 5;
   localparam int CNTW  = 4;
   localparam int SELW  = 2;

   logic                 CLK = 1'b0;
   logic                 nRST;
   logic                 ex_valid;
   logic                 ex_wen;
   logic [REGW-1:0]      ex_dest;
   logic [SELW-1:0]      ex_avail;
   logic [NSRC*REGW-1:0] src_addr;
   logic [NSRC-1:0]      src_used;
   logic                 stall_in;
   logic                 flush;
   logic                 cnt_clr;
   logic [NSRC*SELW-1:0] fwd_sel;
   logic                 hazard_stall;
   logic [CNTW-1:0]      stall_cnt;

   forward_scoreboard #(
      .DEPTH (DEPTH),
      .NSRC  (NSRC),
      .REGW  (REGW),
      .CNTW  (CNTW)
   ) dut (
      .CLK          (CLK),
      .nRST         (nRST),
      .ex_valid     (ex_valid),
      .ex_wen       (ex_wen),
      .ex_dest      (ex_dest),
      .ex_avail     (ex_avail),
      .src_addr     (src_addr),
      .src_used     (src_used),
      .stall_in     (stall_in),
      .flush        (flush),
      .cnt_clr      (cnt_clr),
      .fwd_sel      (fwd_sel),
      .hazard_stall (hazard_stall),
      .stall_cnt    (stall_cnt)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [NSRC*SELW-1:0] sel;
      logic                 hz;
      logic [CNTW-1:0]      cnt;
   } exp_t;

   exp_t            exp_q [$];
   string           tag_q [$];
   int              checks_cnt = 0;
   int              fail_cnt   = 0;
   logic [CNTW-1:0] exp_cnt;

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks_cnt++;
      if (obs !== exp) begin
         fail_cnt++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic w, input logic [4:0] d, input logic [1:0] av,
                        input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] used);
      ex_valid = v;
      ex_wen   = w;
      ex_dest  = d;
      ex_avail = av;
      src_addr = {s1, s0};
      src_used = used;
   endtask

   // One EX cycle: queue expectation, compare at negedge, then cross the edge.
   task automatic step(input string tag, input logic [3:0] sel, input logic hz);
      exp_t  e;
      string t;
      e.sel = sel;
      e.hz  = hz;
      e.cnt = exp_cnt;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(negedge CLK);
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_value({t, ".sel"}, 32'(fwd_sel), 32'(e.sel));
      check_value({t, ".stall"}, 32'(hazard_stall), 32'(e.hz));
      check_value({t, ".cnt"}, 32'(stall_cnt), 32'(e.cnt));
      $display("txn %-10s sel=%h stall=%0d cnt=%0d", t, fwd_sel, hazard_stall, stall_cnt);
      @(posedge CLK);
      if (nRST) begin
         if (cnt_clr)
            exp_cnt = '0;
         else if (hz && !stall_in && exp_cnt != '1)
            exp_cnt = exp_cnt + 1'b1;
      end
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      fail_cnt++;
      $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
      $fatal(1, "watchdog");
   end

   initial begin
      nRST = 1'b0; stall_in = 1'b0; flush = 1'b0; cnt_clr = 1'b0; exp_cnt = '0;
      drive(0, 0, 0, 0, 0, 0, 2'b00);
      step("reset", 4'h0, 0);
      nRST = 1'b1;

      // ALU chain; avail=0 must clamp to 1
      drive(1, 1, 3, 0, 1, 2, 2'b11);  step("alu_prod", 4'h0, 0);
      drive(1, 1, 4, 1, 3, 3, 2'b11);  step("alu_dep", {2'd1, 2'd1}, 0);
      drive(1, 0, 0, 1, 3, 0, 2'b01);  step("alu_wb", {2'd0, 2'd2}, 0);

      // Load-use, ex_valid gating, youngest load wins over an older one
      drive(1, 1, 5, 2, 0, 0, 2'b00);  step("lw_a", 4'h0, 0);
      drive(0, 0, 0, 1, 5, 5, 2'b11);  step("gate_valid", 4'h0, 0);
      drive(1, 1, 5, 2, 0, 0, 2'b00);  step("lw_b", 4'h0, 0);
      drive(1, 1, 6, 1, 5, 5, 2'b11);  step("lu_stall", 4'h0, 1);
      step("lu_fwd", {2'd2, 2'd2}, 0);

      // Priority and src_used
      drive(1, 1, 7, 1, 0, 0, 2'b00);  step("r7_a", 4'h0, 0);
      drive(1, 1, 7, 1, 7, 0, 2'b01);  step("r7_b", {2'd0, 2'd1}, 0);
      drive(1, 0, 0, 1, 7, 7, 2'b11);  step("r7_young", {2'd1, 2'd1}, 0);
      drive(1, 0, 0, 1, 7, 7, 2'b01);  step("r7_unused", {2'd0, 2'd2}, 0);

      // r0 is never forwarded and never stalls
      drive(1, 1, 0, 1, 0, 0, 2'b11);  step("r0_wr", 4'h0, 0);
      drive(1, 1, 0, 2, 0, 0, 2'b11);  step("r0_ld", 4'h0, 0);
      drive(1, 0, 0, 1, 0, 0, 2'b11);  step("r0_rd", 4'h0, 0);

      // Freeze: avail=3 clamps to 2, slots hold, counter does not move
      drive(1, 1, 11, 3, 0, 0, 2'b00); step("lw_r11", 4'h0, 0);
      drive(1, 1, 12, 1, 11, 11, 2'b11);
      stall_in = 1'b1;
      for (int i = 0; i < 3; i++) step("frz", 4'h0, 1);
      stall_in = 1'b0;
      step("frz_rel", 4'h0, 1);
      step("frz_fwd", {2'd2, 2'd2}, 0);

      // Flushed producer never forwards
      drive(1, 1, 13, 1, 0, 0, 2'b00); flush = 1'b1;
      step("flush_wr", 4'h0, 0);
      flush = 1'b0;
      drive(1, 0, 0, 1, 13, 13, 2'b11);
      step("flush_rd1", 4'h0, 0);
      step("flush_rd2", 4'h0, 0);

      // Asynchronous reset between edges
      drive(1, 1, 14, 1, 0, 0, 2'b00); step("r14_wr", 4'h0, 0);
      drive(1, 0, 0, 1, 14, 0, 2'b01); step("r14_rd", {2'd0, 2'd1}, 0);
      #1 nRST = 1'b0; exp_cnt = '0;
      step("rst_mid", 4'h0, 0);
      nRST = 1'b1;
      step("rst_after", 4'h0, 0);

      // Counter saturation at 15, then clear beats increment
      for (int i = 0; i < 20; i++) begin
         drive(1, 1, 15, 3, 0, 0, 2'b00);   step("sat_ld", 4'h0, 0);
         drive(1, 0, 0, 1, 15, 15, 2'b11);  step("sat_use", 4'h0, 1);
      end
      drive(1, 0, 0, 1, 15, 0, 2'b01);   step("sat_fwd", {2'd0, 2'd2}, 0);
      drive(1, 1, 15, 2, 0, 0, 2'b00);   step("clr_ld", 4'h0, 0);
      drive(1, 0, 0, 1, 15, 15, 2'b11);  cnt_clr = 1'b1;
      step("clr_stall", 4'h0, 1);
      cnt_clr = 1'b0;
      drive(0, 0, 0, 1, 0, 0, 2'b00);    step("clr_after", 4'h0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
      $finish;
   end

endmodule
